// File: rtl/cpu_core.sv
// Single-cycle 16-bit RISC core: internal ROM, 8x16 register file, ALU and data RAM.
// Optional retire trace is compiled in when CPU_TRACE_EN is defined.
module cpu_core #(
  parameter string IMEM_INIT_FILE = "program.hex",
  parameter int    IMEM_DEPTH     = 256,
  parameter int    DMEM_DEPTH     = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_dummy
);

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_OR     = 4'h4,
    OP_XOR    = 4'h5,
    OP_SLT    = 4'h6,
    OP_ADDI   = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_BEQ    = 4'hA,
    OP_JMP    = 4'hB,
    OP_LI     = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  logic [15:0] r_imem [IMEM_DEPTH];
  logic [15:0] r_dmem [DMEM_DEPTH];
  logic [15:0] r_regs [8];
  logic [7:0]  r_pc;
  logic        r_halted;

  logic [15:0] w_instr;
  opcode_e     w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic [15:0] w_imm6;
  logic [15:0] w_imm9;
  logic [15:0] w_rdVal;
  logic [15:0] w_rsVal;
  logic [15:0] w_rtVal;
  logic [7:0]  w_dmemAddr;
  logic [15:0] w_wbData;
  logic        w_wbEn;
  logic        w_dmemWe;
  logic        w_halt;
  logic [7:0]  w_nextPc;

  // Unloaded ROM words must decode as NOP; program contents are placed by the environment.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] = '0;
  end

  assign w_instr    = r_imem[r_pc];
  assign w_op       = opcode_e'(w_instr[15:12]);
  assign w_rd       = w_instr[11:9];
  assign w_rs       = w_instr[8:6];
  assign w_rt       = w_instr[5:3];
  assign w_imm6     = {{10{w_instr[5]}}, w_instr[5:0]};
  assign w_imm9     = {{7{w_instr[8]}}, w_instr[8:0]};
  assign w_rdVal    = (w_rd == 3'd0) ? 16'h0000 : r_regs[w_rd];
  assign w_rsVal    = (w_rs == 3'd0) ? 16'h0000 : r_regs[w_rs];
  assign w_rtVal    = (w_rt == 3'd0) ? 16'h0000 : r_regs[w_rt];
  assign w_dmemAddr = w_rsVal[7:0] + w_imm6[7:0];

  always_comb begin
    w_wbData = '0;
    w_wbEn   = 1'b0;
    w_dmemWe = 1'b0;
    w_halt   = 1'b0;
    w_nextPc = r_pc + 8'd1;
    case (w_op)
      OP_ADD:  begin w_wbEn = 1'b1; w_wbData = w_rsVal + w_rtVal; end
      OP_SUB:  begin w_wbEn = 1'b1; w_wbData = w_rsVal - w_rtVal; end
      OP_AND:  begin w_wbEn = 1'b1; w_wbData = w_rsVal & w_rtVal; end
      OP_OR:   begin w_wbEn = 1'b1; w_wbData = w_rsVal | w_rtVal; end
      OP_XOR:  begin w_wbEn = 1'b1; w_wbData = w_rsVal ^ w_rtVal; end
      OP_SLT:  begin
        w_wbEn   = 1'b1;
        w_wbData = {15'b0, ($signed(w_rsVal) < $signed(w_rtVal))};
      end
      OP_ADDI: begin w_wbEn = 1'b1; w_wbData = w_rsVal + w_imm6; end
      OP_LW:   begin w_wbEn = 1'b1; w_wbData = r_dmem[w_dmemAddr]; end
      OP_SW:   w_dmemWe = 1'b1;
      // Branch offset is relative to the following instruction and wraps in 8 bits.
      OP_BEQ:  if (w_rdVal == w_rsVal) w_nextPc = r_pc + 8'd1 + w_imm6[7:0];
      OP_JMP:  w_nextPc = w_instr[7:0];
      OP_LI:   begin w_wbEn = 1'b1; w_wbData = w_imm9; end
      OP_HALT: begin w_halt = 1'b1; w_nextPc = r_pc; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc     <= '0;
      r_halted <= 1'b0;
      o_dummy  <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (!r_halted) begin
      r_pc <= w_nextPc;
      if (w_halt) r_halted <= 1'b1;
      if (w_wbEn && (w_rd != 3'd0)) begin
        r_regs[w_rd] <= w_wbData;
        o_dummy      <= w_wbData[0];
      end
    end
  end

  // Data RAM is deliberately left out of reset so contents survive a restart.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !r_halted && w_dmemWe) r_dmem[w_dmemAddr] <= w_rdVal;
  end

`ifdef CPU_TRACE_EN
  always @(posedge i_clk) begin
    if (!i_rst && !r_halted) begin
      if (w_dmemWe)
        $display("[TRACE] t=%0t pc=%02h instr=%04h mem[%02h]<=%04h",
                 $time, r_pc, w_instr, w_dmemAddr, w_rdVal);
      else if (w_wbEn && (w_rd != 3'd0))
        $display("[TRACE] t=%0t pc=%02h instr=%04h r%0d<=%04h",
                 $time, r_pc, w_instr, w_rd, w_wbData);
      else
        $display("[TRACE] t=%0t pc=%02h instr=%04h", $time, r_pc, w_instr);
    end
  end
`else
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: programs are written straight into the core's ROM,
// then registers, PC, data RAM and o_dummy are checked against hand-computed values.
module tb_cpu_core;

  logic i_clk;
  logic i_rst;
  logic o_dummy;

  int checkCount = 0;
  int failCount  = 0;

  logic [15:0] progBuf [256];

  cpu_core #(
    .IMEM_INIT_FILE(""),
    .IMEM_DEPTH    (256),
    .DMEM_DEPTH    (256)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_dummy(o_dummy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] encR(logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] encI(logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [5:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [15:0] encLi(logic [2:0] rd, logic [8:0] imm);
    return {4'hC, rd, imm};
  endfunction

  function automatic logic [15:0] encJmp(logic [7:0] addr);
    return {4'hB, 4'h0, addr};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < 256; i++) progBuf[i] = 16'h0000;
  endtask

  // Holds reset across one rising edge while the new program is copied into ROM.
  task automatic applyStimulus();
    i_rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.r_imem[i] = progBuf[i];
    @(negedge i_clk);
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    #1;

    // ALU program; also used for the initial reset check.
    clearProg();
    progBuf[0]  = encLi(3'd1, 9'd5);
    progBuf[1]  = encLi(3'd2, 9'd3);
    progBuf[2]  = encR(4'h1, 3'd3, 3'd1, 3'd2);
    progBuf[3]  = encR(4'h2, 3'd4, 3'd1, 3'd2);
    progBuf[4]  = encR(4'h6, 3'd5, 3'd2, 3'd1);
    progBuf[5]  = encR(4'h3, 3'd6, 3'd1, 3'd2);
    progBuf[6]  = encR(4'h4, 3'd7, 3'd1, 3'd2);
    progBuf[7]  = encR(4'h5, 3'd6, 3'd1, 3'd2);
    progBuf[8]  = encI(4'h7, 3'd7, 3'd7, 6'h38);
    progBuf[9]  = encR(4'h6, 3'd5, 3'd1, 3'd7);
    progBuf[10] = 16'hF000;
    applyStimulus();
    $display("[TB] reset state");
    checkOutput("rst_pc", {8'h00, dut.r_pc}, 16'h0000);
    checkOutput("rst_dummy", {15'b0, o_dummy}, 16'h0000);
    for (int i = 1; i < 8; i++) checkOutput($sformatf("rst_r%0d", i), dut.r_regs[i], 16'h0000);
    i_rst = 1'b0;

    $display("[TB] ALU program");
    runCycles(3);
    checkOutput("alu_add_r3", dut.r_regs[3], 16'h0008);
    checkOutput("alu_dummy_add", {15'b0, o_dummy}, 16'h0000);
    runCycles(1);
    checkOutput("alu_sub_r4", dut.r_regs[4], 16'h0002);
    runCycles(1);
    checkOutput("alu_slt_r5", dut.r_regs[5], 16'h0001);
    checkOutput("alu_dummy_slt", {15'b0, o_dummy}, 16'h0001);
    runCycles(1);
    checkOutput("alu_and_r6", dut.r_regs[6], 16'h0001);
    runCycles(1);
    checkOutput("alu_or_r7", dut.r_regs[7], 16'h0007);
    runCycles(1);
    checkOutput("alu_xor_r6", dut.r_regs[6], 16'h0006);
    runCycles(1);
    checkOutput("alu_addi_neg_r7", dut.r_regs[7], 16'hFFFF);
    runCycles(1);
    checkOutput("alu_slt_signed_r5", dut.r_regs[5], 16'h0000);
    checkOutput("alu_dummy_final", {15'b0, o_dummy}, 16'h0000);
    runCycles(3);
    checkOutput("alu_halt_pc", {8'h00, dut.r_pc}, 16'h000A);

    $display("[TB] memory program");
    clearProg();
    progBuf[0] = encLi(3'd1, -9'd7);
    progBuf[1] = encI(4'h9, 3'd1, 3'd0, 6'd4);
    progBuf[2] = encI(4'h8, 3'd2, 3'd0, 6'd4);
    progBuf[3] = encLi(3'd3, 9'd255);
    progBuf[4] = encI(4'h9, 3'd1, 3'd3, 6'd2);
    progBuf[5] = encI(4'h8, 3'd4, 3'd0, 6'd1);
    progBuf[6] = 16'hF000;
    applyStimulus();
    i_rst = 1'b0;
    runCycles(1);
    checkOutput("mem_li_neg_r1", dut.r_regs[1], 16'hFFF9);
    runCycles(2);
    checkOutput("mem_sw_dmem4", dut.r_dmem[4], 16'hFFF9);
    checkOutput("mem_lw_r2", dut.r_regs[2], 16'hFFF9);
    checkOutput("mem_dummy", {15'b0, o_dummy}, 16'h0001);
    runCycles(3);
    checkOutput("mem_wrap_dmem1", dut.r_dmem[1], 16'hFFF9);
    checkOutput("mem_wrap_lw_r4", dut.r_regs[4], 16'hFFF9);

    $display("[TB] control program");
    clearProg();
    progBuf[0] = encLi(3'd1, 9'd1);
    progBuf[1] = encI(4'hA, 3'd1, 3'd0, 6'd5);
    progBuf[2] = encI(4'hA, 3'd1, 3'd1, 6'd1);
    progBuf[3] = encLi(3'd2, 9'd9);
    progBuf[4] = encJmp(8'd7);
    progBuf[5] = encLi(3'd3, 9'd4);
    progBuf[6] = 16'h0000;
    progBuf[7] = 16'hF000;
    progBuf[8] = encLi(3'd3, 9'd4);
    applyStimulus();
    i_rst = 1'b0;
    runCycles(2);
    checkOutput("ctl_beq_not_taken_pc", {8'h00, dut.r_pc}, 16'h0002);
    runCycles(1);
    checkOutput("ctl_beq_taken_pc", {8'h00, dut.r_pc}, 16'h0004);
    runCycles(1);
    checkOutput("ctl_jmp_pc", {8'h00, dut.r_pc}, 16'h0007);
    runCycles(50);
    checkOutput("ctl_halt_frozen_pc", {8'h00, dut.r_pc}, 16'h0007);
    checkOutput("ctl_skipped_r2", dut.r_regs[2], 16'h0000);
    checkOutput("ctl_skipped_r3", dut.r_regs[3], 16'h0000);

    $display("[TB] PC wrap program");
    clearProg();
    progBuf[0]   = encI(4'h7, 3'd1, 3'd1, 6'd1);
    progBuf[1]   = encJmp(8'd255);
    progBuf[255] = 16'h0000;
    applyStimulus();
    i_rst = 1'b0;
    runCycles(2);
    checkOutput("wrap_pc_ff", {8'h00, dut.r_pc}, 16'h00FF);
    runCycles(1);
    checkOutput("wrap_pc_0", {8'h00, dut.r_pc}, 16'h0000);
    runCycles(1);
    checkOutput("wrap_rerun_r1", dut.r_regs[1], 16'h0002);

    $display("[TB] r0 protection program");
    clearProg();
    progBuf[0] = encLi(3'd0, 9'd7);
    progBuf[1] = encR(4'h1, 3'd1, 3'd0, 3'd0);
    progBuf[2] = encI(4'h7, 3'd2, 3'd0, 6'd3);
    progBuf[3] = encLi(3'd0, -9'd2);
    progBuf[4] = 16'hF000;
    applyStimulus();
    i_rst = 1'b0;
    runCycles(1);
    checkOutput("r0_dummy_unchanged", {15'b0, o_dummy}, 16'h0000);
    runCycles(1);
    checkOutput("r0_add_r1", dut.r_regs[1], 16'h0000);
    runCycles(1);
    checkOutput("r0_addi_r2", dut.r_regs[2], 16'h0003);
    runCycles(1);
    checkOutput("r0_dummy_held", {15'b0, o_dummy}, 16'h0001);

    $display("[TB] reset mid-run");
    clearProg();
    progBuf[0] = encLi(3'd1, 9'd5);
    progBuf[1] = encI(4'h8, 3'd2, 3'd0, 6'd4);
    progBuf[2] = encI(4'h7, 3'd2, 3'd2, 6'd1);
    progBuf[3] = encI(4'h9, 3'd2, 3'd0, 6'd4);
    progBuf[7] = 16'hF000;
    applyStimulus();
    i_rst = 1'b0;
    runCycles(6);
    checkOutput("mid_pc6", {8'h00, dut.r_pc}, 16'h0006);
    checkOutput("mid_r1", dut.r_regs[1], 16'h0005);
    checkOutput("mid_dmem4_first", dut.r_dmem[4], 16'hFFFA);
    applyStimulus();
    checkOutput("mid_rst_pc", {8'h00, dut.r_pc}, 16'h0000);
    checkOutput("mid_rst_r1", dut.r_regs[1], 16'h0000);
    checkOutput("mid_rst_r2", dut.r_regs[2], 16'h0000);
    checkOutput("mid_rst_dummy", {15'b0, o_dummy}, 16'h0000);
    checkOutput("mid_rst_dmem_kept", dut.r_dmem[4], 16'hFFFA);
    i_rst = 1'b0;
    runCycles(4);
    checkOutput("mid_rerun_pc", {8'h00, dut.r_pc}, 16'h0004);
    checkOutput("mid_rerun_r2", dut.r_regs[2], 16'hFFFB);
    checkOutput("mid_rerun_dmem4", dut.r_dmem[4], 16'hFFFB);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
